// File: rtl/bcast_buf.sv
// bcast_buf: one-input, two-output broadcast buffer.
// Every accepted din item is delivered once on dout0 and once on dout1,
// in order. The item stays in the head register until both outputs have
// taken it. Each output tracks its own "already sent" flag, so the two
// consumers may complete in any order without losing or repeating data.
// Build option BCAST_BUF_SKID_EN: adds a second (tail) entry and a
// registered din_ready, which removes the combinational path from
// doutN_ready to din_ready. Without it, the buffer has a single entry
// and din_ready is combinational.
module bcast_buf #(
  parameter int DIN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DIN-1:0] din_data,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [DIN-1:0] dout0_data,
  output logic           dout0_valid,
  input  logic           dout0_ready,
  output logic [DIN-1:0] dout1_data,
  output logic           dout1_valid,
  input  logic           dout1_ready
);

  logic           head_valid;
  logic [DIN-1:0] head_data;
  logic           sent0;
  logic           sent1;
  logic           hs0;
  logic           hs1;
  logic           retire;
  logic           accept;

  assign dout0_data = head_data;
  assign dout1_data = head_data;

  // Per-output valid/handshake. The head retires once each output has
  // either already sent the item or is sending it in this cycle.
  always_comb begin
    dout0_valid = head_valid & ~sent0;
    dout1_valid = head_valid & ~sent1;
    hs0         = dout0_valid & dout0_ready;
    hs1         = dout1_valid & dout1_ready;
    retire      = head_valid & (sent0 | hs0) & (sent1 | hs1);
    accept      = din_valid & din_ready;
  end

`ifdef BCAST_BUF_SKID_EN

  logic           tail_valid;
  logic [DIN-1:0] tail_data;
  logic           ready_q;
  logic [1:0]     occ_next;

  assign din_ready = ready_q;

  // Occupancy after this cycle's accept/retire. It never exceeds 2 because
  // ready_q is low whenever both entries are full.
  always_comb begin
    occ_next = {1'b0, head_valid} + {1'b0, tail_valid}
             + {1'b0, accept} - {1'b0, retire};
  end

  // Two-entry in-order buffer. The tail moves into the head on retire.
  // din_ready is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      sent0      <= 1'b0;
      sent1      <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      ready_q    <= 1'b1;
    end else begin
      ready_q <= (occ_next < 2'd2);
      if (retire) begin
        sent0 <= 1'b0;
        sent1 <= 1'b0;
        if (tail_valid) begin
          head_data <= tail_data;
          if (accept) begin
            tail_data <= din_data;
          end else begin
            tail_valid <= 1'b0;
          end
        end else if (accept) begin
          head_data <= din_data;
        end else begin
          head_valid <= 1'b0;
        end
      end else begin
        sent0 <= sent0 | hs0;
        sent1 <= sent1 | hs1;
        if (accept) begin
          if (head_valid) begin
            tail_data  <= din_data;
            tail_valid <= 1'b1;
          end else begin
            head_data  <= din_data;
            head_valid <= 1'b1;
          end
        end
      end
    end
  end

`else

  // Single entry. A new item can load in the same cycle that the head
  // retires, so there is no bubble when both outputs are ready.
  assign din_ready = ~head_valid | retire;

  // Head register and sent flags. A freshly loaded item always starts
  // with both sent flags clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      sent0      <= 1'b0;
      sent1      <= 1'b0;
    end else if (accept) begin
      head_valid <= 1'b1;
      head_data  <= din_data;
      sent0      <= 1'b0;
      sent1      <= 1'b0;
    end else if (retire) begin
      head_valid <= 1'b0;
      sent0      <= 1'b0;
      sent1      <= 1'b0;
    end else begin
      sent0 <= sent0 | hs0;
      sent1 <= sent1 | hs1;
    end
  end

`endif

endmodule
